gpio_irq_bank: RTL and testbench
================================

Name: gpio_irq_bank

Overview:
- Parametrised memory-mapped GPIO peripheral; successor to the fixed 8-bit GPIO block behind the core's address[31]=1 window.
- Adds per-pin direction, atomic set/clear/toggle of outputs, multi-stage input synchroniser, and rising/falling-edge interrupt capture with sticky write-1-to-clear status.
- Registered bus response, one cycle after each access.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (minimum 2).
- RESET_DIR, 0, reset value of DIR (WIDTH bits; 1 = output).
- RESET_OUT, 0, reset value of OUT (WIDTH bits).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- read  in  1  bus read strobe, single-cycle.
- write  in  1  bus write strobe, single-cycle.
- address  in  32  byte address; only address[5:2] decoded.
- write_data  in  32  write data.
- read_data  out  32  read data, valid when response=1.
- response  out  1  access-complete pulse.
- gpios_in  in  WIDTH  asynchronous pad inputs.
- gpios_out  out  WIDTH  pad output values (= OUT).
- direction  out  WIDTH  pad output enables (= DIR).
- irq  out  1  OR of (STATUS) bits.

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: DIR=RESET_DIR, OUT=RESET_OUT, RISE_EN=0, FALL_EN=0, STATUS=0, synchroniser and previous-sample registers=0, read_data=0, response=0, irq=0, prime counter=0.
- Register map (address[5:2]); bits above WIDTH read 0 and ignore writes:
  - 0 DIR, RW.
  - 1 OUT, RW.
  - 2 IN, RO; synchronised pin value.
  - 3 OUT_SET, WO; OUT |= wd.
  - 4 OUT_CLR, WO; OUT &= ~wd.
  - 5 OUT_TGL, WO; OUT ^= wd.
  - 6 RISE_EN, RW.
  - 7 FALL_EN, RW.
  - 8 STATUS, RW1C.
  - 9..15 unmapped: read 0, writes ignored.
  - WO registers read 0.
- Access timing:
  - Strobe sampled at edge N; register update takes effect at edge N.
  - response=1 and read_data valid during cycle N+1; response deasserts after one cycle unless a new strobe arrives.
  - read_data holds its last value until the next read.
  - Back-to-back accesses every cycle are supported.
  - read and write together: write executes; read_data returns the pre-write value; one response pulse.
- Synchroniser and edge detection:
  - gpios_in passes through SYNC_STAGES flops to give IN; prev = IN delayed one cycle.
  - rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN.
  - STATUS |= rise | fall each cycle.
  - Edge capture suppressed until the prime counter reaches SYNC_STAGES+1 cycles after reset release. This avoids false edges from pins tied high.
- STATUS write-1-to-clear colliding with a new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq is combinational from the STATUS register only (registered source, glitch-free).
- Input pins are synchronised regardless of DIR, so IN reflects pad loopback when a pin is an output.
- Asserting rst_n low mid-access: all state returns to reset immediately; no response is issued for the aborted access.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants: GPIO_DIR=0 through GPIO_STATUS=8;
  - GPIO_OFFSET_MSB=5 and GPIO_OFFSET_LSB=2.
- Sub-module gpio_sync (per-bus multi-stage synchroniser, parameters WIDTH and SYNC_STAGES) is natural and reusable for other pad inputs.
- Edge and status logic stays in gpio_irq_bank.

Test Plan:
- Reset, then read 0x00/0x04/0x20 -> read_data 0x0, response exactly one cycle after each strobe; direction=0, gpios_out=0, irq=0.
- Write OUT=0xA5, then OUT_SET=0x0F, OUT_CLR=0x81, OUT_TGL=0xFF -> gpios_out sequence A5, AF, 2E, D1; read of 0x04 returns 0x000000D1.
- RISE_EN=0x01, drive gpios_in[0] 0->1 -> IN[0] high after 2 cycles; STATUS=0x01 and irq=1 one cycle later; write STATUS=0x01 -> irq=0 next cycle.
- FALL_EN=0x80, toggle gpios_in[7] 1->0 in the same cycle the synchronised falling edge meets a STATUS write 0x80 -> STATUS[7] stays 1.
- gpios_in=0xFF held through reset release with RISE_EN=FALL_EN=0xFF -> STATUS stays 0 (prime suppression).
- Simultaneous read+write to 0x00 with wd=0x3C while DIR=0x11 -> read_data=0x11, direction=0x3C; then read 0x3C (0xF) -> read_data 0, response 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and address-decode field shared by the GPIO bank
package gpio_pkg;
    localparam int GPIO_OFFSET_MSB = 5;
    localparam int GPIO_OFFSET_LSB = 2;
    typedef logic [GPIO_OFFSET_MSB-GPIO_OFFSET_LSB:0] gpio_offset_t;
    localparam gpio_offset_t GPIO_DIR     = 4'd0;
    localparam gpio_offset_t GPIO_OUT     = 4'd1;
    localparam gpio_offset_t GPIO_IN      = 4'd2;
    localparam gpio_offset_t GPIO_OUT_SET = 4'd3;
    localparam gpio_offset_t GPIO_OUT_CLR = 4'd4;
    localparam gpio_offset_t GPIO_OUT_TGL = 4'd5;
    localparam gpio_offset_t GPIO_RISE_EN = 4'd6;
    localparam gpio_offset_t GPIO_FALL_EN = 4'd7;
    localparam gpio_offset_t GPIO_STATUS  = 4'd8;
endpackage

// File: rtl/gpio_irq_bank_if.sv
// gpio_irq_bank_if: single-cycle strobe bus with registered one-cycle response
// master drives read/write/address/write_data; slave returns read_data/response
interface gpio_irq_bank_if;
    import gpio_pkg::*;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;
    modport master(output read, write, address, write_data, input read_data, response);
    modport slave(input read, write, address, write_data, output read_data, response);
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage flop synchroniser for a bus of asynchronous inputs
// ports: clk, rst_n (async active-low), d (async in), q (synchronised out)
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage <= '0;
        else        stage <= {stage[SYNC_STAGES-2:0], d};
    end
    assign q = stage[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: memory-mapped GPIO with direction, set/clr/toggle and edge interrupts
// ports: clk, rst_n (async active-low), bus (slave side of gpio_irq_bank_if),
//        gpios_in (pads), gpios_out (= OUT), direction (= DIR), irq (OR of STATUS)
module gpio_irq_bank
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpio_irq_bank_if.slave        bus,
    input  logic [WIDTH-1:0]      gpios_in,
    output logic [WIDTH-1:0]      gpios_out,
    output logic [WIDTH-1:0]      direction,
    output logic                  irq
);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
    logic [WIDTH-1:0] dir_r, out_r, rise_en, fall_en, status, in_sync, prev;
    logic [WIDTH-1:0] wd, edges, out_n, status_n;
    logic [PW-1:0]    prime;
    logic             primed;
    gpio_offset_t     off;
    logic [31:0]      rd_mux;
    logic             unused_bus;
    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (gpios_in),
        .q    (in_sync)
    );
    assign unused_bus = ^{bus.address[31:GPIO_OFFSET_MSB+1], bus.address[GPIO_OFFSET_LSB-1:0], bus.write_data};
    // Until the synchroniser and prev register hold real pad samples, a pin tied
    // high would look like a rising edge, so capture waits for the prime count.
    always_comb begin
        off      = bus.address[GPIO_OFFSET_MSB:GPIO_OFFSET_LSB];
        wd       = bus.write_data[WIDTH-1:0];
        primed   = prime == PRIME_DONE;
        edges    = primed ? (in_sync & ~prev & rise_en) | (~in_sync & prev & fall_en) : '0;
        out_n    = !bus.write              ? out_r :
                   off == GPIO_OUT         ? wd :
                   off == GPIO_OUT_SET     ? out_r | wd :
                   off == GPIO_OUT_CLR     ? out_r & ~wd :
                   off == GPIO_OUT_TGL     ? out_r ^ wd : out_r;
        // new edges are OR'ed after the clear so a same-cycle edge wins
        status_n = (bus.write && off == GPIO_STATUS ? status & ~wd : status) | edges;
        rd_mux   = '0;
        case (off)
            GPIO_DIR:     rd_mux = 32'(dir_r);
            GPIO_OUT:     rd_mux = 32'(out_r);
            GPIO_IN:      rd_mux = 32'(in_sync);
            GPIO_RISE_EN: rd_mux = 32'(rise_en);
            GPIO_FALL_EN: rd_mux = 32'(fall_en);
            GPIO_STATUS:  rd_mux = 32'(status);
            default:      rd_mux = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r         <= RESET_DIR;
            out_r         <= RESET_OUT;
            rise_en       <= '0;
            fall_en       <= '0;
            status        <= '0;
            prev          <= '0;
            prime         <= '0;
            bus.read_data <= '0;
            bus.response  <= 1'b0;
        end else begin
            dir_r        <= bus.write && off == GPIO_DIR     ? wd : dir_r;
            rise_en      <= bus.write && off == GPIO_RISE_EN ? wd : rise_en;
            fall_en      <= bus.write && off == GPIO_FALL_EN ? wd : fall_en;
            out_r        <= out_n;
            status       <= status_n;
            prev         <= in_sync;
            prime        <= primed ? prime : prime + 1'b1;
            bus.response <= bus.read | bus.write;
            if (bus.read) bus.read_data <= rd_mux;
        end
    end
    assign gpios_out = out_r;
    assign direction = dir_r;
    assign irq       = |status;
endmodule

// File: tb/tb_gpio_irq_bank.sv
// tb_gpio_irq_bank: scoreboard bench with a behavioural model of the GPIO bank
module tb_gpio_irq_bank;
    localparam int W  = 8;
    localparam int SS = 2;
    logic clk, rst_n;
    logic [W-1:0] gpios_in, gpios_out, direction;
    logic irq;
    int checks = 0;
    int errors = 0;
    gpio_irq_bank_if bus_if ();
    gpio_irq_bank #(.WIDTH(W), .SYNC_STAGES(SS), .RESET_DIR('0), .RESET_OUT('0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .gpios_in (gpios_in),
        .gpios_out(gpios_out),
        .direction(direction),
        .irq      (irq)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask
    // Behavioural model: register file as plain variables, pad history as a
    // queue of per-edge samples (index k = sample taken k edges ago).
    logic [W-1:0]  m_dir = '0, m_out = '0, m_ren = '0, m_fen = '0, m_st = '0;
    logic [31:0]   m_last = '0;
    logic [W-1:0]  hist[$];
    logic [31:0]   exp_q[$];
    logic [W-1:0]  m_in, m_prv, m_ev, m_wd;
    logic [3:0]    m_off;
    logic [31:0]   m_rv;
    function automatic logic [31:0] mread(input logic [3:0] o, input logic [W-1:0] inv);
        case (o)
            4'd0: return 32'(m_dir);
            4'd1: return 32'(m_out);
            4'd2: return 32'(inv);
            4'd6: return 32'(m_ren);
            4'd7: return 32'(m_fen);
            4'd8: return 32'(m_st);
            default: return 32'h0;
        endcase
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir = '0; m_out = '0; m_ren = '0; m_fen = '0; m_st = '0; m_last = '0;
            hist.delete();
            exp_q.delete();
        end else begin
            hist.push_front(gpios_in);
            m_in  = hist.size() > SS ? hist[SS] : '0;
            m_prv = hist.size() > SS + 1 ? hist[SS+1] : '0;
            m_ev  = hist.size() > SS + 1 ? ((m_in & ~m_prv & m_ren) | (~m_in & m_prv & m_fen)) : '0;
            if (hist.size() > SS + 2) void'(hist.pop_back());
            m_off = bus_if.address[5:2];
            m_wd  = bus_if.write_data[W-1:0];
            m_rv  = mread(m_off, m_in);
            if (bus_if.read || bus_if.write) exp_q.push_back(bus_if.read ? m_rv : m_last);
            if (bus_if.read) m_last = m_rv;
            if (bus_if.write) begin
                case (m_off)
                    4'd0: m_dir = m_wd;
                    4'd1: m_out = m_wd;
                    4'd3: m_out = m_out | m_wd;
                    4'd4: m_out = m_out & ~m_wd;
                    4'd5: m_out = m_out ^ m_wd;
                    4'd6: m_ren = m_wd;
                    4'd7: m_fen = m_wd;
                    4'd8: m_st  = m_st & ~m_wd;
                    default: ;
                endcase
            end
            m_st = m_st | m_ev;
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("direction", 32'(direction), 32'(m_dir));
            chk("gpios_out", 32'(gpios_out), 32'(m_out));
            chk("irq", 32'(irq), 32'(|m_st));
            if (bus_if.response || exp_q.size() != 0) begin
                chk("response", 32'(bus_if.response), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) chk("read_data", bus_if.read_data, exp_q.pop_front());
            end
        end
    end
    task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus_if.read = r;
        bus_if.write = w;
        bus_if.address = a;
        bus_if.write_data = d;
        @(negedge clk);
        bus_if.read = 1'b0;
        bus_if.write = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        gpios_in = '0;
        bus_if.read = 1'b0;
        bus_if.write = 1'b0;
        bus_if.address = '0;
        bus_if.write_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_dir", 32'(direction), 32'h0);
        chk("reset_out", 32'(gpios_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_resp", 32'(bus_if.response), 32'h0);
        acc(1, 0, 32'h00, 0);
        acc(1, 0, 32'h04, 0);
        acc(1, 0, 32'h20, 0);
        chk("reset_rd_status", bus_if.read_data, 32'h0);
        @(negedge clk);
        chk("resp_one_cycle", 32'(bus_if.response), 32'h0);
        acc(0, 1, 32'h04, 32'hA5); chk("out_wr", 32'(gpios_out), 32'hA5);
        acc(0, 1, 32'h0C, 32'h0F); chk("out_set", 32'(gpios_out), 32'hAF);
        acc(0, 1, 32'h10, 32'h81); chk("out_clr", 32'(gpios_out), 32'h2E);
        acc(0, 1, 32'h14, 32'hFF); chk("out_tgl", 32'(gpios_out), 32'hD1);
        acc(1, 0, 32'h04, 0);      chk("out_rd", bus_if.read_data, 32'hD1);
        acc(0, 1, 32'h18, 32'h01);
        repeat (2) @(negedge clk);
        gpios_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        acc(1, 0, 32'h08, 0);
        chk("in_rd", bus_if.read_data, 32'h01);
        chk("rise_irq", 32'(irq), 32'h1);
        acc(0, 1, 32'h20, 32'h01);
        chk("w1c_irq", 32'(irq), 32'h0);
        acc(0, 1, 32'h1C, 32'h80);
        gpios_in[7] = 1'b1;
        repeat (4) @(negedge clk);
        gpios_in[7] = 1'b0;
        repeat (2) @(negedge clk);
        acc(0, 1, 32'h20, 32'h80);
        chk("collide_irq", 32'(irq), 32'h1);
        acc(1, 0, 32'h20, 0);
        chk("collide_status", bus_if.read_data, 32'h80);
        acc(0, 1, 32'h20, 32'hFF);
        acc(0, 1, 32'h00, 32'h11);
        acc(1, 1, 32'h00, 32'h3C);
        chk("rw_read_old", bus_if.read_data, 32'h11);
        chk("rw_dir_new", 32'(direction), 32'h3C);
        acc(1, 0, 32'h3C, 0);
        chk("unmapped_rd", bus_if.read_data, 32'h0);
        chk("unmapped_resp", 32'(bus_if.response), 32'h1);
        gpios_in = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc(0, 1, 32'h18, 32'hFF);
        acc(0, 1, 32'h1C, 32'hFF);
        repeat (4) @(negedge clk);
        acc(1, 0, 32'h20, 0);
        chk("prime_status", bus_if.read_data, 32'h0);
        chk("prime_irq", 32'(irq), 32'h0);
        acc(0, 1, 32'h00, 32'h5A);
        bus_if.read = 1'b1;
        bus_if.address = 32'h04;
        @(posedge clk);
        #1;
        bus_if.read = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_resp", 32'(bus_if.response), 32'h0);
        chk("abort_dir", 32'(direction), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) gpios_in = W'($urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            else begin
                logic r, w;
                r = 1'($urandom);
                w = r ? 1'($urandom) : 1'b1;
                acc(r, w, {$urandom_range(0, 3) == 0 ? 26'($urandom) : 26'h0, 4'($urandom_range(0, 15)), 2'($urandom)},
                    $urandom_range(0, 2) == 0 ? $urandom : 32'($urandom_range(0, 255)));
            end
        end
        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
